// File: rtl/score_keeper.sv
// Score and session high-score tracker for the Flappy Bird game.
// Counts cleared pipes during play, freezes on game over, and keeps the best score until reset.
module score_keeper #(
    parameter int MAX_SCORE = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pass_pipe,
    input  logic       game_over,
    output logic [6:0] score,
    output logic [6:0] high_score,
    output logic       active,
    output logic       new_record
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [6:0] SCORE_MAX = 7'(MAX_SCORE);

    state_t     state_q, state_d;
    logic [6:0] score_q, score_d;
    logic [6:0] high_q, high_d;
    logic       new_record_q, new_record_d;
    logic       active_q;
    logic       pass_prev;

    // The limit is tested before adding so the 7-bit count can never wrap.
    function automatic logic [6:0] sat_inc(input logic [6:0] val);
        if (val >= SCORE_MAX) begin
            return SCORE_MAX;
        end
        return val + 7'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        high_d       = high_q;
        new_record_d = new_record_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = 7'd0;
                end
            end
            PLAY: begin
                if (game_over) begin
                    state_d      = OVER;
                    high_d       = (score_q > high_q) ? score_q : high_q;
                    new_record_d = (score_q > high_q);
                end else if (pass_pipe && !pass_prev) begin
                    score_d = sat_inc(score_q);
                end
            end
            OVER: begin
                if (start) begin
                    state_d      = PLAY;
                    score_d      = 7'd0;
                    new_record_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            score_q      <= 7'd0;
            high_q       <= 7'd0;
            new_record_q <= 1'b0;
            active_q     <= 1'b0;
            pass_prev    <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_q       <= high_d;
            new_record_q <= new_record_d;
            active_q     <= (state_d == PLAY);
            pass_prev    <= pass_pipe;
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign active     = active_q;
    assign new_record = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a behavioural model pushes expected outputs
// into a queue as each cycle's stimulus is driven; they are popped and compared after the edge.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       reset, start, pass_pipe, game_over;
    logic [6:0] score, high_score;
    logic       active, new_record;

    int checks = 0;
    int errors = 0;

    score_keeper #(.MAX_SCORE(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pass_pipe  (pass_pipe),
        .game_over  (game_over),
        .score      (score),
        .high_score (high_score),
        .active     (active),
        .new_record (new_record)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] score;
        logic [6:0] high;
        logic       act;
        logic       nr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: 0 idle, 1 play, 2 over
    int m_state = 0;
    int m_score = 0;
    int m_high  = 0;
    int m_nr    = 0;
    int m_prev  = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model(input int s, input int p, input int g, input int r);
        if (r != 0) begin
            m_state = 0; m_score = 0; m_high = 0; m_nr = 0; m_prev = 0;
            return;
        end
        if (m_state == 0) begin
            if (s != 0) begin
                m_state = 1; m_score = 0;
            end
        end else if (m_state == 1) begin
            if (g != 0) begin
                m_state = 2;
                m_nr = (m_score > m_high) ? 1 : 0;
                if (m_score > m_high) m_high = m_score;
            end else if (p != 0 && m_prev == 0) begin
                m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
            end
        end else begin
            if (s != 0) begin
                m_state = 1; m_score = 0; m_nr = 0;
            end
        end
        m_prev = p;
    endtask

    task automatic cyc(input logic s, input logic p, input logic g, input logic r);
        exp_t e;
        start = s; pass_pipe = p; game_over = g; reset = r;
        model(int'(s), int'(p), int'(g), int'(r));
        e.score = 7'(m_score);
        e.high  = 7'(m_high);
        e.act   = (m_state == 1);
        e.nr    = (m_nr != 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("score", int'(score), int'(e.score));
            chk("high_score", int'(high_score), int'(e.high));
            chk("active", int'(active), int'(e.act));
            chk("new_record", int'(new_record), int'(e.nr));
        end
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi; j++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < lo; j++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic play_round(input int n);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(n, 1, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        start = 1'b0; pass_pipe = 1'b0; game_over = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_score", int'(score), 0);
        chk("rst_active", int'(active), 0);

        // Ignored inputs in IDLE
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Start then five 3-high / 2-low pulses
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(5, 3, 2);
        chk("five_pulses", int'(score), 5);
        chk("five_active", int'(active), 1);

        // Saturation
        pulses(120, 1, 1);
        chk("sat_99", int'(score), 99);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_high", int'(high_score), 99);

        // Record handling from a fresh session
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        play_round(7);
        chk("rec7_high", int'(high_score), 7);
        chk("rec7_nr", int'(new_record), 1);
        play_round(7);
        chk("eq7_high", int'(high_score), 7);
        chk("eq7_nr", int'(new_record), 0);
        play_round(3);
        chk("low3_high", int'(high_score), 7);

        // Game over racing a pass edge, then toggling in OVER
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(4, 1, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("race_score", int'(score), 4);
        chk("race_high", int'(high_score), 4);
        pulses(3, 1, 1);
        chk("over_frozen", int'(score), 4);

        // pass_pipe already high at start
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_zero", int'(score), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_rearm", int'(score), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Continuous start: re-enters PLAY right after game over
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_active", int'(active), 1);

        // Reset mid-round with score 12, high 20
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        play_round(20);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(12, 1, 1);
        chk("pre_rst_score", int'(score), 12);
        chk("pre_rst_high", int'(high_score), 20);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_score", int'(score), 0);
        chk("mid_rst_high", int'(high_score), 0);
        chk("mid_rst_active", int'(active), 0);
        chk("mid_rst_nr", int'(new_record), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 30) == 0), ($urandom_range(0, 150) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
